// File: rtl/utc_pkg.sv
// Shared opcodes, sequencer states and instruction-field helpers for the
// parametrised accumulator core.
package utc_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDAI = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_LDBI = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_STA  = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_LDA  = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_BCS  = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  // The opcode always occupies the top nibble of the instruction word.
  function automatic int opcode_lsb(input int data_w);
    return data_w - OPCODE_W;
  endfunction

  function automatic logic is_imm_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDAI) || (op == OP_LDBI);
  endfunction

endpackage

// File: rtl/utc_alu.sv
// Combinational ALU: computes the EXEC-stage accumulator result and carry,
// and reports which architectural registers the opcode updates.
module utc_alu
  import utc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic [DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   result,
  output logic                carry_out,
  output logic                writes_acc,
  output logic                writes_c
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, acc} + {1'b0, b};

  // NOTE: every output gets a default first so no path through the case
  // leaves a value unassigned and infers a latch.
  always_comb begin
    result     = '0;
    carry_out  = 1'b0;
    writes_acc = 1'b0;
    writes_c   = 1'b0;
    unique case (op)
      OP_ADD: begin
        result     = w_sum[DATA_W-1:0];
        carry_out  = w_sum[DATA_W];
        writes_acc = 1'b1;
        writes_c   = 1'b1;
      end
      OP_SUB: begin
        result     = acc - b;
        carry_out  = (acc < b);
        writes_acc = 1'b1;
        writes_c   = 1'b1;
      end
      OP_AND: begin
        result     = acc & b;
        writes_acc = 1'b1;
      end
      OP_OR: begin
        result     = acc | b;
        writes_acc = 1'b1;
      end
      OP_XOR: begin
        result     = acc ^ b;
        writes_acc = 1'b1;
      end
      OP_NOT: begin
        result     = ~acc;
        writes_acc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/utc_core_param.sv
// Parametrised accumulator CPU: FETCH/DECODE/IMM/EXEC sequencer, unified
// program/data memory with a load port and a combinational debug read port.
module utc_core_param
  import utc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        flags_out,
  output logic              halted
);

  localparam int OP_LSB = opcode_lsb(DATA_W);
  localparam int DEPTH  = 2 ** ADDR_W;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_b;
  logic [ADDR_W-1:0]   r_pc;
  logic [OPCODE_W-1:0] r_ir_op;
  logic [ADDR_W-1:0]   r_ir_addr;
  logic                r_c;
  logic                r_z;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   w_mem_pc;
  logic [DATA_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_carry;
  logic                w_alu_writes_acc;
  logic                w_alu_writes_c;
  logic                w_advance;

  assign w_mem_pc   = r_mem[r_pc];
  assign w_mem_addr = r_mem[r_ir_addr];
  assign w_advance  = run && !load_en;

  utc_alu #(.DATA_W(DATA_W)) u_alu (
    .op         (r_ir_op),
    .acc        (r_acc),
    .b          (r_b),
    .result     (w_alu_result),
    .carry_out  (w_alu_carry),
    .writes_acc (w_alu_writes_acc),
    .writes_c   (w_alu_writes_c)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = is_imm_op(r_ir_op) ? S_IMM : S_EXEC;
      S_IMM:    w_state_next = S_EXEC;
      S_EXEC:   w_state_next = (r_ir_op == OP_HLT) ? S_HALT : S_FETCH;
      default:  w_state_next = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_acc     <= '0;
      r_b       <= '0;
      r_pc      <= '0;
      r_ir_op   <= '0;
      r_ir_addr <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
    end else if (w_advance) begin
      r_state <= w_state_next;
      unique case (r_state)
        S_FETCH: begin
          r_ir_op   <= w_mem_pc[OP_LSB +: OPCODE_W];
          r_ir_addr <= w_mem_pc[ADDR_W-1:0];
          r_pc      <= r_pc + ADDR_W'(1);
        end
        S_IMM: begin
          r_pc <= r_pc + ADDR_W'(1);
          if (r_ir_op == OP_LDAI) begin
            r_acc <= w_mem_pc;
            r_z   <= (w_mem_pc == '0);
          end else begin
            r_b <= w_mem_pc;
          end
        end
        S_EXEC: begin
          if (w_alu_writes_acc) begin
            r_acc <= w_alu_result;
            r_z   <= (w_alu_result == '0);
          end
          if (w_alu_writes_c) r_c <= w_alu_carry;
          // Branches read the flags as they stood when EXEC began.
          unique case (r_ir_op)
            OP_LDA: begin
              r_acc <= w_mem_addr;
              r_z   <= (w_mem_addr == '0);
            end
            OP_JMP: r_pc <= r_ir_addr;
            OP_BEQ: if (r_z)  r_pc <= r_ir_addr;
            OP_BNE: if (!r_z) r_pc <= r_ir_addr;
            OP_BCS: if (r_c)  r_pc <= r_ir_addr;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // NOTE: memory has no reset so a loaded program survives rst; rst only
  // blocks writes, which keeps an in-flight STA from landing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_en) begin
        r_mem[load_addr] <= load_data;
      end else if (run && r_state == S_EXEC && r_ir_op == OP_STA) begin
        r_mem[r_ir_addr] <= r_acc;
      end
    end
  end

  assign dbg_data  = r_mem[dbg_addr];
  assign acc_out   = r_acc;
  assign pc_out    = r_pc;
  assign flags_out = {r_c, r_z};
  assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_utc_core_param.sv
// Directed bench for utc_core_param: default 8/4 instance plus a 12/6
// instance, with expected values queued ahead of each observation.
module tb_utc_core_param;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit data / 4-bit address instance
  logic        a_rst = 1'b0, a_run = 1'b0, a_load_en = 1'b0;
  logic [3:0]  a_load_addr = '0, a_dbg_addr = '0, a_pc;
  logic [7:0]  a_load_data = '0, a_dbg_data, a_acc;
  logic [1:0]  a_flags;
  logic        a_halted;

  // 12-bit data / 6-bit address instance
  logic        b_rst = 1'b0, b_run = 1'b0, b_load_en = 1'b0;
  logic [5:0]  b_load_addr = '0, b_dbg_addr = '0, b_pc;
  logic [11:0] b_load_data = '0, b_dbg_data, b_acc;
  logic [1:0]  b_flags;
  logic        b_halted;

  utc_core_param #(.DATA_W(8), .ADDR_W(4)) dut_a (
    .clk(clk), .rst(a_rst), .run(a_run), .load_en(a_load_en),
    .load_addr(a_load_addr), .load_data(a_load_data),
    .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data),
    .acc_out(a_acc), .pc_out(a_pc), .flags_out(a_flags), .halted(a_halted)
  );

  utc_core_param #(.DATA_W(12), .ADDR_W(6)) dut_b (
    .clk(clk), .rst(b_rst), .run(b_run), .load_en(b_load_en),
    .load_addr(b_load_addr), .load_data(b_load_data),
    .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data),
    .acc_out(b_acc), .pc_out(b_pc), .flags_out(b_flags), .halted(b_halted)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag: tag, val: v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h with no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic load_a(input logic [3:0] addr, input logic [7:0] data);
    a_load_en = 1'b1; a_load_addr = addr; a_load_data = data;
    step(1);
    a_load_en = 1'b0;
  endtask

  task automatic load_b(input logic [5:0] addr, input logic [11:0] data);
    b_load_en = 1'b1; b_load_addr = addr; b_load_data = data;
    step(1);
    b_load_en = 1'b0;
  endtask

  task automatic reset_a();
    a_run = 1'b0; a_rst = 1'b1;
    step(1);
    a_rst = 1'b0;
  endtask

  initial begin
    // ---- Reset and basic program: LDA#05 LDB#03 ADD STA F HLT ----
    a_rst = 1'b1;
    step(2);
    a_rst = 1'b0;
    expect_val("rst_acc", 32'h0);    check(32'(a_acc));
    expect_val("rst_pc", 32'h0);     check(32'(a_pc));
    expect_val("rst_flags", 32'h0);  check(32'(a_flags));
    expect_val("rst_halted", 32'h0); check(32'(a_halted));

    load_a(4'd0, 8'h10); load_a(4'd1, 8'h05); load_a(4'd2, 8'h80);
    load_a(4'd3, 8'h03); load_a(4'd4, 8'h20); load_a(4'd5, 8'h9F);
    load_a(4'd6, 8'hF0);
    a_run = 1'b1;
    expect_val("basic_acc_c4", 32'h05);  step(4); check(32'(a_acc));
    expect_val("basic_acc_c11", 32'h08); step(7); check(32'(a_acc));
    expect_val("basic_halted", 32'h1);   step(6); check(32'(a_halted));
    expect_val("basic_pc", 32'h7);       check(32'(a_pc));
    a_dbg_addr = 4'd15; #1;
    expect_val("basic_mem15", 32'h08);   check(32'(a_dbg_data));
    step(3);
    expect_val("halt_pc_stays", 32'h7);  check(32'(a_pc));
    expect_val("halt_stays", 32'h1);     check(32'(a_halted));

    // ---- Carry/zero: LDA#FF LDB#01 ADD BCS 9 ----
    reset_a();
    load_a(4'd0, 8'h10); load_a(4'd1, 8'hFF); load_a(4'd2, 8'h80);
    load_a(4'd3, 8'h01); load_a(4'd4, 8'h20); load_a(4'd5, 8'hE9);
    load_a(4'd9, 8'hF0);
    a_run = 1'b1;
    step(11);
    expect_val("carry_acc", 32'h00);     check(32'(a_acc));
    expect_val("carry_flags", 32'h3);    check(32'(a_flags));
    step(3);
    expect_val("bcs_taken_pc", 32'h9);   check(32'(a_pc));

    // ---- Borrow: LDA#03 LDB#05 SUB BEQ 8 BNE 9 ----
    reset_a();
    load_a(4'd0, 8'h10); load_a(4'd1, 8'h03); load_a(4'd2, 8'h80);
    load_a(4'd3, 8'h05); load_a(4'd4, 8'h30); load_a(4'd5, 8'hC8);
    load_a(4'd6, 8'hD9); load_a(4'd7, 8'hF0); load_a(4'd8, 8'hF0);
    a_run = 1'b1;
    step(11);
    expect_val("borrow_acc", 32'hFE);    check(32'(a_acc));
    expect_val("borrow_flags", 32'h2);   check(32'(a_flags));
    step(3);
    expect_val("beq_not_taken_pc", 32'h6); check(32'(a_pc));
    step(3);
    expect_val("bne_taken_pc", 32'h9);   check(32'(a_pc));
    step(3);
    expect_val("hlt9_halted", 32'h1);    check(32'(a_halted));
    expect_val("hlt9_pc", 32'hA);        check(32'(a_pc));

    // ---- Hold/resume on the same program ----
    reset_a();
    a_run = 1'b1;
    step(6);  // LDB# now sits in IMM, not yet executed
    expect_val("pre_hold_pc", 32'h3);    check(32'(a_pc));
    a_run = 1'b0;
    step(5);
    expect_val("hold_pc", 32'h3);        check(32'(a_pc));
    expect_val("hold_acc", 32'h03);      check(32'(a_acc));
    expect_val("hold_flags", 32'h0);     check(32'(a_flags));
    a_run = 1'b1;
    step(2);  // IMM + EXEC; next cycle is FETCH of SUB
    expect_val("resume_pc", 32'h4);      check(32'(a_pc));
    a_load_en = 1'b1; a_load_addr = 4'd14; a_load_data = 8'h77;
    step(1);
    a_load_en = 1'b0;
    expect_val("load_hold_pc", 32'h4);   check(32'(a_pc));
    step(3);
    expect_val("resume_sub_acc", 32'hFE); check(32'(a_acc));
    expect_val("resume_sub_pc", 32'h5);  check(32'(a_pc));
    a_dbg_addr = 4'd14; #1;
    expect_val("load_mem14", 32'h77);    check(32'(a_dbg_data));

    // ---- PC wrap: OR at 0, JMP 15, LDA# at 15 with operand at 0 ----
    reset_a();
    load_a(4'd0, 8'h5A); load_a(4'd1, 8'hBF); load_a(4'd15, 8'h10);
    a_run = 1'b1;
    step(10);
    expect_val("wrap_acc", 32'h5A);      check(32'(a_acc));
    expect_val("wrap_pc", 32'h1);        check(32'(a_pc));
    expect_val("wrap_flags", 32'h0);     check(32'(a_flags));

    // ---- Reset during EXEC of STA ----
    reset_a();
    load_a(4'd0, 8'h10); load_a(4'd1, 8'h42); load_a(4'd2, 8'h9D);
    load_a(4'd3, 8'hF0); load_a(4'd13, 8'h11);
    a_run = 1'b1;
    step(6);  // STA is in EXEC during the next cycle
    a_rst = 1'b1;
    step(1);
    a_rst = 1'b0; a_run = 1'b0;
    expect_val("midrst_acc", 32'h0);     check(32'(a_acc));
    expect_val("midrst_pc", 32'h0);      check(32'(a_pc));
    expect_val("midrst_flags", 32'h0);   check(32'(a_flags));
    expect_val("midrst_halted", 32'h0);  check(32'(a_halted));
    a_dbg_addr = 4'd13; #1;
    expect_val("midrst_no_write", 32'h11); check(32'(a_dbg_data));
    a_dbg_addr = 4'd0; #1;
    expect_val("midrst_prog_intact", 32'h10); check(32'(a_dbg_data));
    a_run = 1'b1;
    step(4);
    expect_val("rerun_acc", 32'h42);     check(32'(a_acc));
    step(3);
    a_dbg_addr = 4'd13; #1;
    expect_val("rerun_sta_mem13", 32'h42); check(32'(a_dbg_data));

    // ---- 12-bit / 6-bit instance: LDA#805 LDB#703 ADD STA 63 HLT ----
    b_rst = 1'b1;
    step(1);
    b_rst = 1'b0;
    expect_val("w12_rst_pc", 32'h0);     check(32'(b_pc));
    load_b(6'd0, 12'h100); load_b(6'd1, 12'h805); load_b(6'd2, 12'h800);
    load_b(6'd3, 12'h703); load_b(6'd4, 12'h200); load_b(6'd5, 12'h93F);
    load_b(6'd6, 12'hF00);
    b_run = 1'b1;
    expect_val("w12_acc_c4", 32'h805);   step(4); check(32'(b_acc));
    expect_val("w12_acc_c11", 32'hF08);  step(7); check(32'(b_acc));
    expect_val("w12_flags", 32'h0);      check(32'(b_flags));
    expect_val("w12_halted", 32'h1);     step(6); check(32'(b_halted));
    expect_val("w12_pc", 32'h7);         check(32'(b_pc));
    b_dbg_addr = 6'd63; #1;
    expect_val("w12_mem63", 32'hF08);    check(32'(b_dbg_data));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
